// File: rtl/cbx_pkg.sv
// Shared definitions for the cbx counter family: mode constants and the helpers
// used to size counters and detect the terminal count.
package cbx_pkg;

   localparam bit CBX_WRAP = 1'b0;
   localparam bit CBX_SAT  = 1'b1;

   function automatic int cbx_clog2(input longint unsigned value);
      int n;
      longint unsigned v;
      n = 0;
      v = (value > 64'd0) ? value - 64'd1 : 64'd0;
      while (v > 64'd0) begin
         n++;
         v = v >> 1;
      end
      return n;
   endfunction

   // Operands are 33 bits so that a full 32-bit counter with MODULUS=2**32 still fits.
   function automatic logic cbx_term(input logic [32:0] q, input logic up,
                                     input logic [32:0] modulus);
      return up ? (q == (modulus - 33'd1)) : (q == 33'd0);
   endfunction

endpackage

// File: rtl/cbx_term_detect.sv
// Terminal-count compare: high when the next count in the selected direction
// must wrap (or saturate).
module cbx_term_detect
   import cbx_pkg::*;
#(
   parameter int          WIDTH   = 8,
   parameter logic [32:0] MODULUS = 33'd1 << WIDTH
)(
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   output logic             term
);

   assign term = cbx_term(33'(q), up, MODULUS);

endmodule

// File: rtl/cbx_updown_counter.sv
// Modulo-N up/down counter with asynchronous clear, synchronous load,
// cascade carry/borrow and registered wrap/overflow status.
module cbx_updown_counter
   import cbx_pkg::*;
#(
   parameter int          WIDTH    = 8,
   parameter logic [32:0] MODULUS  = 33'd1 << WIDTH,
   parameter bit          SATURATE = CBX_WRAP
)(
   input  logic             CLK,
   input  logic             CDN,
   input  logic             CAI,
   input  logic             UP,
   input  logic             SLOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             CAO,
   output logic             WRAP,
   output logic             OVF
);

   localparam logic [WIDTH:0]   MAX_EXT = MODULUS[WIDTH:0] - (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];

   if (WIDTH < 1 || WIDTH > 32 || MODULUS < 33'd2 || MODULUS > (33'd1 << WIDTH)) begin : g_bad_param
      $error("cbx_updown_counter: illegal WIDTH/MODULUS combination");
   end

   logic [WIDTH-1:0] q_reg;
   logic             wrap_reg;
   logic             ovf_reg;
   logic             term;

   cbx_term_detect #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_term (
      .q    (q_reg),
      .up   (UP),
      .term (term)
   );

   always_ff @(posedge CLK or negedge CDN) begin
      if (!CDN) begin
         q_reg    <= '0;
         wrap_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (SLOAD) begin
         // Out-of-range load values clamp so Q never leaves 0..MODULUS-1.
         q_reg    <= ({1'b0, D} > MAX_EXT) ? MAX_Q : D;
         wrap_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (CAI) begin
         if (!term) begin
            q_reg    <= UP ? q_reg + WIDTH'(1) : q_reg - WIDTH'(1);
            wrap_reg <= 1'b0;
         end else if (SATURATE == CBX_WRAP) begin
            q_reg    <= UP ? '0 : MAX_Q;
            wrap_reg <= 1'b1;
         end else begin
            ovf_reg  <= 1'b1;
            wrap_reg <= 1'b0;
         end
      end else begin
         wrap_reg <= 1'b0;
      end
   end

   // Combinational so a cascade of stages advances on the same edge.
   assign CAO  = CAI & term & ~SLOAD & (SATURATE == CBX_WRAP);
   assign Q    = q_reg;
   assign WRAP = wrap_reg;
   assign OVF  = ovf_reg;

endmodule

// File: tb/tb_cbx_updown_counter.sv
// Randomised scoreboard bench: a wrap, a saturate and a full-range counter share
// stimulus, plus a two-stage decimal cascade, all against an arithmetic model.
module tb_cbx_updown_counter;

   logic       clk = 1'b0;
   logic       cdn = 1'b1;
   logic       cai = 1'b0, up = 1'b1, sload = 1'b0;
   logic [3:0] d = 4'd0;
   logic       c_en = 1'b0, c_up = 1'b1;

   logic [3:0] q0, q1, lo_q, hi_q;
   logic [2:0] q2;
   logic       cao0, cao1, cao2, lo_cao, hi_cao;
   logic       wrap0, wrap1, wrap2, lo_wrap, hi_wrap;
   logic       ovf0, ovf1, ovf2, lo_ovf, hi_ovf;

   always #5 clk = ~clk;

   cbx_updown_counter #(.WIDTH(4), .MODULUS(33'd10), .SATURATE(1'b0)) dut_wrap (
      .CLK(clk), .CDN(cdn), .CAI(cai), .UP(up), .SLOAD(sload), .D(d),
      .Q(q0), .CAO(cao0), .WRAP(wrap0), .OVF(ovf0));

   cbx_updown_counter #(.WIDTH(4), .MODULUS(33'd10), .SATURATE(1'b1)) dut_sat (
      .CLK(clk), .CDN(cdn), .CAI(cai), .UP(up), .SLOAD(sload), .D(d),
      .Q(q1), .CAO(cao1), .WRAP(wrap1), .OVF(ovf1));

   cbx_updown_counter #(.WIDTH(3)) dut_full (
      .CLK(clk), .CDN(cdn), .CAI(cai), .UP(up), .SLOAD(sload), .D(d[2:0]),
      .Q(q2), .CAO(cao2), .WRAP(wrap2), .OVF(ovf2));

   cbx_updown_counter #(.WIDTH(4), .MODULUS(33'd10)) dut_lo (
      .CLK(clk), .CDN(cdn), .CAI(c_en), .UP(c_up), .SLOAD(1'b0), .D(4'd0),
      .Q(lo_q), .CAO(lo_cao), .WRAP(lo_wrap), .OVF(lo_ovf));

   cbx_updown_counter #(.WIDTH(4), .MODULUS(33'd10)) dut_hi (
      .CLK(clk), .CDN(cdn), .CAI(lo_cao), .UP(c_up), .SLOAD(1'b0), .D(4'd0),
      .Q(hi_q), .CAO(hi_cao), .WRAP(hi_wrap), .OVF(hi_ovf));

   typedef struct packed {
      logic [2:0][3:0] q;
      logic [2:0]      w;
      logic [2:0]      o;
      logic [2:0]      c;
      logic [3:0]      lo;
      logic [3:0]      hi;
      logic            ccao;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0, n_total = 0, txn = 0, hi_pulses = 0;

   // Reference model state: plain integers, one slot per single-stage counter.
   int mq [3];
   bit mw [3], mo [3];
   int modv [3] = '{10, 10, 8};
   bit satv [3] = '{1'b0, 1'b1, 1'b0};
   int cv = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic void model_clear();
      for (int k = 0; k < 3; k++) begin
         mq[k] = 0; mw[k] = 1'b0; mo[k] = 1'b0;
      end
      cv = 0;
   endfunction

   task automatic drive(input bit i_cai, input bit i_up, input bit i_sload, input int i_d,
                        input bit i_cen, input bit i_cup);
      exp_t e;
      @(negedge clk);
      cai = i_cai; up = i_up; sload = i_sload; d = 4'(i_d);
      c_en = i_cen; c_up = i_cup;
      for (int k = 0; k < 3; k++) begin
         int dk;
         bit term;
         dk   = (k == 2) ? (i_d % 8) : i_d;
         term = i_up ? (mq[k] == modv[k] - 1) : (mq[k] == 0);
         e.c[k] = i_cai && term && !i_sload && !satv[k];
         if (i_sload) begin
            mq[k] = (dk < modv[k] - 1) ? dk : modv[k] - 1;
            mw[k] = 1'b0; mo[k] = 1'b0;
         end else if (i_cai) begin
            if (term && satv[k]) begin
               mo[k] = 1'b1; mw[k] = 1'b0;
            end else begin
               mq[k] = (mq[k] + (i_up ? 1 : modv[k] - 1)) % modv[k];
               mw[k] = term;
            end
         end else begin
            mw[k] = 1'b0;
         end
         e.q[k] = 4'(mq[k]); e.w[k] = mw[k]; e.o[k] = mo[k];
      end
      e.ccao = i_cen && (i_cup ? (cv == 99) : (cv == 0));
      if (i_cen) cv = (cv + (i_cup ? 1 : 99)) % 100;
      e.lo = 4'(cv % 10);
      e.hi = 4'(cv / 10);
      sb.push_back(e);
   endtask

   task automatic do_reset();
      cdn = 1'b0;
      #1;
      check("rst_q_wrap", 32'(q0), 0);
      check("rst_q_sat", 32'(q1), 0);
      check("rst_q_full", 32'(q2), 0);
      check("rst_wrap_flag", 32'(wrap0), 0);
      check("rst_ovf_flag", 32'(ovf1), 0);
      check("rst_cascade", 32'({hi_q, lo_q}), 0);
      @(posedge clk);
      #1;
      check("rst_hold_q_wrap", 32'(q0), 0);
      check("rst_hold_q_full", 32'(q2), 0);
      #1;
      cdn = 1'b1;
      model_clear();
   endtask

   task automatic midcycle_reset();
      @(posedge clk);
      @(negedge clk);
      #2;
      do_reset();
   endtask

   // Monitor: CAO sampled just before the edge, registered outputs just after.
   initial begin
      exp_t            e;
      logic [2:0]      a_c;
      logic            a_cc;
      logic [2:0][3:0] a_q;
      logic [2:0]      a_w, a_o;
      forever begin
         @(negedge clk);
         #4;
         a_c  = {cao2, cao1, cao0};
         a_cc = hi_cao;
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            txn++;
            a_q = {{1'b0, q2}, q1, q0};
            a_w = {wrap2, wrap1, wrap0};
            a_o = {ovf2, ovf1, ovf0};
            if (a_cc) hi_pulses++;
            $display("txn %0d: q=%0d/%0d/%0d wrap=%b ovf=%b cao=%b chain=%0d%0d", txn,
                     q0, q1, q2, a_w, a_o, a_c, hi_q, lo_q);
            for (int k = 0; k < 3; k++) begin
               check($sformatf("q[%0d]", k), 32'(a_q[k]), 32'(e.q[k]));
               check($sformatf("wrap[%0d]", k), 32'(a_w[k]), 32'(e.w[k]));
               check($sformatf("ovf[%0d]", k), 32'(a_o[k]), 32'(e.o[k]));
               check($sformatf("cao[%0d]", k), 32'(a_c[k]), 32'(e.c[k]));
            end
            check("chain_lo", 32'(lo_q), 32'(e.lo));
            check("chain_hi", 32'(hi_q), 32'(e.hi));
            check("chain_cao", 32'(a_cc), 32'(e.ccao));
         end
      end
   end

   initial begin
      model_clear();
      #2;
      do_reset();
      // Count up through the decimal wrap.
      for (int i = 0; i < 12; i++) drive(1, 1, 0, 0, 0, 1);
      // Count down from reset: immediate borrow at zero.
      midcycle_reset();
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1);
      // Load 7 then count into saturation; a load clears OVF.
      drive(0, 1, 1, 7, 0, 1);
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 1);
      drive(0, 1, 1, 0, 0, 1);
      // Clamped load, then load colliding with a terminal count.
      drive(0, 1, 1, 15, 0, 1);
      drive(1, 1, 1, 15, 0, 1);
      // Cascade of two decades for 100 clocks.
      midcycle_reset();
      hi_pulses = 0;
      for (int i = 0; i < 100; i++) drive(0, 1, 0, 0, 1, 1);
      @(posedge clk);
      #2;
      check("chain_cao_pulses", 32'(hi_pulses), 1);
      // Asynchronous clear in the middle of a count.
      midcycle_reset();
      for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 1, 1);
      midcycle_reset();
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1, 1);
      // Randomised traffic.
      begin
         bit r_up, r_cup;
         r_up = 1'b1; r_cup = 1'b1;
         for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) r_up = ~r_up;
            if ($urandom_range(0, 31) == 0) r_cup = ~r_cup;
            drive($urandom_range(0, 3) != 0, r_up, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, r_cup);
         end
      end
      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
